// File: rtl/pcie_gen12_scrambler.sv
// PCIe Gen1/Gen2 per-lane (de)scrambler with ordered-set tracking,
// variable active byte count and valid/ready handshake on both sides.

package pcie_gen12_scrambler_pkg;
  typedef enum logic [1:0] {ST_DATA, ST_OS_FIRST, ST_OS_TS, ST_OS_K} scr_st_e;
endpackage

// One symbol slot: applies scramble rules to a single byte and hands the
// updated LFSR / ordered-set state on to the next slot in the beat.
module pcie_gen12_scr_sym
  import pcie_gen12_scrambler_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic        i_en,
  input  logic        i_dis,
  input  logic [7:0]  i_data,
  input  logic        i_k,
  input  logic [15:0] i_lfsr,
  input  scr_st_e     i_st,
  input  logic [3:0]  i_cnt,
  output logic [7:0]  o_data,
  output logic [15:0] o_lfsr,
  output scr_st_e     o_st,
  output logic [3:0]  o_cnt
);
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K_SKP = 8'h1C;
  localparam logic [7:0] K_FTS = 8'h3C;
  localparam logic [7:0] K_IDL = 8'h7C;

  logic [7:0]  w_key;
  logic [15:0] w_adv;
  logic        w_com, w_skp, w_os_k;

  assign w_com  = i_k & (i_data == K_COM);
  assign w_skp  = i_k & (i_data == K_SKP);
  assign w_os_k = i_k & ((i_data == K_SKP) | (i_data == K_FTS) | (i_data == K_IDL));

  // Eight Galois shifts; each key bit is the LFSR MSB before its shift
  always_comb begin
    w_adv = i_lfsr;
    w_key = '0;
    for (int b = 0; b < 8; b++) begin
      w_key[b] = w_adv[15];
      w_adv    = {w_adv[14:0], 1'b0} ^ (w_adv[15] ? 16'h0039 : 16'h0000);
    end
  end

  // Symbol rules and ordered-set next state
  always_comb begin
    o_data = i_data;
    o_lfsr = i_lfsr;
    o_st   = i_st;
    o_cnt  = i_cnt;
    if (!i_en) begin
      o_data = '0;
    end else if (w_com) begin
      o_lfsr = LFSR_SEED;
      o_st   = ST_OS_FIRST;
      o_cnt  = '0;
    end else begin
      if (!w_skp) o_lfsr = w_adv;
      if (!i_k && !i_dis && (i_st != ST_OS_TS)) o_data = i_data ^ w_key;
      case (i_st)
        // A D symbol right after COM is treated as payload, not a TS body
        ST_OS_FIRST: begin
          if (w_os_k) o_st = ST_OS_K;
          else if (i_k) begin
            o_st  = ST_OS_TS;
            o_cnt = 4'd14;
          end else o_st = ST_DATA;
        end
        ST_OS_TS: begin
          o_cnt = i_cnt - 4'd1;
          if (i_cnt <= 4'd1) begin
            o_st  = ST_DATA;
            o_cnt = '0;
          end
        end
        ST_OS_K: if (!i_k) o_st = ST_DATA;
        default: ;
      endcase
    end
  end
endmodule

module pcie_gen12_scrambler
  import pcie_gen12_scrambler_pkg::*;
#(
  parameter int          NUM_BYTES = 4,
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [2:0]             active_bytes_i,
  input  logic                   scr_disable_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [8*NUM_BYTES-1:0] in_data_i,
  input  logic [NUM_BYTES-1:0]   in_k_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [8*NUM_BYTES-1:0] out_data_o,
  output logic [NUM_BYTES-1:0]   out_k_o
);
  logic [15:0]                 r_lfsr;
  scr_st_e                     r_st;
  logic [3:0]                  r_cnt;
  logic                        r_out_valid;
  logic [8*NUM_BYTES-1:0]      r_out_data;
  logic [NUM_BYTES-1:0]        r_out_k;

  logic                        w_accept;
  logic [NUM_BYTES-1:0]        w_en;
  logic [NUM_BYTES-1:0][7:0]   w_sym;
  logic [15:0]                 w_lfsr_nxt;
  scr_st_e                     w_st_nxt;
  logic [3:0]                  w_cnt_nxt;

  assign in_ready_o = ~r_out_valid | out_ready_i;
  assign w_accept   = in_valid_i & in_ready_o;

  // Byte slots chained in time order; state ripples slot to slot
  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_sym
    logic [15:0] w_lfsr_i, w_lfsr_o;
    scr_st_e     w_st_i, w_st_o;
    logic [3:0]  w_cnt_i, w_cnt_o;

    if (g == 0) begin : g_head
      assign w_lfsr_i = r_lfsr;
      assign w_st_i   = r_st;
      assign w_cnt_i  = r_cnt;
    end else begin : g_link
      assign w_lfsr_i = g_sym[g-1].w_lfsr_o;
      assign w_st_i   = g_sym[g-1].w_st_o;
      assign w_cnt_i  = g_sym[g-1].w_cnt_o;
    end

    assign w_en[g] = (3'(g) < active_bytes_i);

    pcie_gen12_scr_sym #(.LFSR_SEED(LFSR_SEED)) u_sym (
      .i_en   (w_en[g]),
      .i_dis  (scr_disable_i),
      .i_data (in_data_i[8*g +: 8]),
      .i_k    (in_k_i[g]),
      .i_lfsr (w_lfsr_i),
      .i_st   (w_st_i),
      .i_cnt  (w_cnt_i),
      .o_data (w_sym[g]),
      .o_lfsr (w_lfsr_o),
      .o_st   (w_st_o),
      .o_cnt  (w_cnt_o)
    );
  end

  assign w_lfsr_nxt = g_sym[NUM_BYTES-1].w_lfsr_o;
  assign w_st_nxt   = g_sym[NUM_BYTES-1].w_st_o;
  assign w_cnt_nxt  = g_sym[NUM_BYTES-1].w_cnt_o;

  // Scrambler state advances only on an accepted beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
      r_st   <= ST_DATA;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_lfsr <= w_lfsr_nxt;
      r_st   <= w_st_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Output register: load on accept, hold while stalled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_k     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sym;
      r_out_k     <= in_k_i & w_en;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_k_o     = r_out_k;
endmodule

// File: tb/tb_pcie_gen12_scrambler.sv
// Directed vector bench for pcie_gen12_scrambler (NUM_BYTES = 4).
module tb_pcie_gen12_scrambler;
  localparam int NB = 4;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  act;
    logic        dis;
    logic [31:0] ed;
    logic [3:0]  ek;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      active;
  logic            scr_dis;
  logic            in_valid;
  logic            in_ready;
  logic [8*NB-1:0] in_data;
  logic [NB-1:0]   in_k;
  logic            out_valid;
  logic            out_ready;
  logic [8*NB-1:0] out_data;
  logic [NB-1:0]   out_k;

  int n_chk = 0;
  int n_err = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  pcie_gen12_scrambler #(.NUM_BYTES(NB), .LFSR_SEED(16'hFFFF)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .active_bytes_i (active),
    .scr_disable_i  (scr_dis),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_k_i         (in_k),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_k_o        (out_k)
  );

  function automatic vec_t mk(input logic [31:0] d, input logic [3:0] k, input int act,
                              input logic dis, input logic [31:0] ed, input logic [3:0] ek);
    vec_t v;
    v.d = d; v.k = k; v.act = 3'(act); v.dis = dis; v.ed = ed; v.ek = ek;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic send(input vec_t v, input string nm);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v.d;
    in_k     = v.k;
    scr_dis  = v.dis;
    @(posedge clk);
    #1;
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"}, out_data, v.ed);
    chk({nm, " k"}, 32'(out_k), 32'(v.ek));
  endtask

  initial begin
    // Scramble sequence after COM: FF 17 C0 14 B2 E7 02 82 ... byte15 = 8D
    // COM then D 00
    tv.push_back(mk(32'h000000BC, 4'b0001, 4, 1'b0, 32'hC017FFBC, 4'b0001));
    tv.push_back(mk(32'h00000000, 4'b0000, 4, 1'b0, 32'h02E7B214, 4'b0000));
    // COM + 3 SKP: SKPs do not advance the LFSR
    tv.push_back(mk(32'h1C1C1CBC, 4'b1111, 4, 1'b0, 32'h1C1C1CBC, 4'b1111));
    tv.push_back(mk(32'h00000000, 4'b0000, 4, 1'b0, 32'h14C017FF, 4'b0000));
    tv.push_back(mk(32'h00000000, 4'b0000, 4, 1'b0, 32'h8202E7B2, 4'b0000));
    // TS1: COM PAD PAD FF 02 00 4A x10, then D 00 + IDLs
    tv.push_back(mk(32'hFFF7F7BC, 4'b0111, 4, 1'b0, 32'hFFF7F7BC, 4'b0111));
    tv.push_back(mk(32'h4A4A0002, 4'b0000, 4, 1'b0, 32'h4A4A0002, 4'b0000));
    tv.push_back(mk(32'h4A4A4A4A, 4'b0000, 4, 1'b0, 32'h4A4A4A4A, 4'b0000));
    tv.push_back(mk(32'h4A4A4A4A, 4'b0000, 4, 1'b0, 32'h4A4A4A4A, 4'b0000));
    tv.push_back(mk(32'h7C7C7C00, 4'b1110, 4, 1'b0, 32'h7C7C7C8D, 4'b1110));
    // Scrambling disabled alongside COM; XOR resumes at byte 7 (82)
    tv.push_back(mk(32'h000000BC, 4'b0001, 4, 1'b1, 32'h000000BC, 4'b0001));
    tv.push_back(mk(32'h00000000, 4'b0000, 4, 1'b1, 32'h00000000, 4'b0000));
    tv.push_back(mk(32'h7C7C7C00, 4'b1110, 4, 1'b0, 32'h7C7C7C82, 4'b1110));
    // One active byte; junk in upper bytes must be masked
    tv.push_back(mk(32'hAAAAAABC, 4'b1111, 1, 1'b0, 32'h000000BC, 4'b0001));
    tv.push_back(mk(32'h55AA3300, 4'b1110, 1, 1'b0, 32'h000000FF, 4'b0000));
    tv.push_back(mk(32'h12345600, 4'b0110, 1, 1'b0, 32'h00000017, 4'b0000));
    tv.push_back(mk(32'hFFFFFF00, 4'b0000, 1, 1'b0, 32'h000000C0, 4'b0000));
    tv.push_back(mk(32'h01020300, 4'b1000, 1, 1'b0, 32'h00000014, 4'b0000));
    // Two active bytes
    tv.push_back(mk(32'hAAAA00BC, 4'b1101, 2, 1'b0, 32'h0000FFBC, 4'b0001));
    tv.push_back(mk(32'hFFFF0000, 4'b1100, 2, 1'b0, 32'h0000C017, 4'b0000));
    tv.push_back(mk(32'h0F0F0000, 4'b0000, 2, 1'b0, 32'h0000B214, 4'b0000));

    rst_n = 1'b0; active = 3'd4; scr_dis = 1'b0; in_valid = 1'b0;
    in_data = '0; in_k = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset data", out_data, 32'h0);
    chk("reset k", 32'(out_k), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].act != active) begin
        @(negedge clk);
        in_valid = 1'b0;
        active   = tv[i].act;
        @(posedge clk);
      end
      send(tv[i], $sformatf("vec%0d", i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    active   = 3'd4;
    scr_dis  = 1'b0;
    @(posedge clk);

    // Backpressure: output held, no LFSR advance, gap-free resume
    send(mk(32'h000000BC, 4'b0001, 4, 1'b0, 32'hC017FFBC, 4'b0001), "bp A");
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = '0;
    in_k      = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp stall%0d data", c), out_data, 32'hC017FFBC);
      chk($sformatf("bp stall%0d in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp stall%0d valid", c), 32'(out_valid), 32'd1);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp B data", out_data, 32'h02E7B214);
    chk("bp B valid", 32'(out_valid), 32'd1);
    send(mk(32'h7C7C7C00, 4'b1110, 4, 1'b0, 32'h7C7C7C82, 4'b1110), "bp C");

    // Reset while an output beat is stalled: beat dropped, state back to seed/DATA
    @(negedge clk);
    out_ready = 1'b0;
    in_data   = 32'h00000000;
    in_k      = 4'b0000;
    @(posedge clk);
    #1;
    chk("mid-rst pre valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid-rst valid", 32'(out_valid), 32'd0);
    chk("mid-rst data", out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(mk(32'h00000000, 4'b0000, 4, 1'b0, 32'h14C017FF, 4'b0000), "post-rst");
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
